// File: rtl/control_actuadores_if.sv
// Sensor pulses, frame/tick/ack strobes and actuator drives of the fire-control block.
interface control_actuadores_if;
  logic       TempAlto;
  logic       TempMedio;
  logic       HumoOut;
  logic       Elec;
  logic       EJECD;
  logic       Tick;
  logic       Ack;
  logic       Rociador;
  logic       Ventilador;
  logic       Alarma;
  logic       CorteElec;
  logic [1:0] Estado;

  modport master (
    output TempAlto, TempMedio, HumoOut, Elec, EJECD, Tick, Ack,
    input  Rociador, Ventilador, Alarma, CorteElec, Estado
  );

  modport slave (
    input  TempAlto, TempMedio, HumoOut, Elec, EJECD, Tick, Ack,
    output Rociador, Ventilador, Alarma, CorteElec, Estado
  );
endinterface

// File: rtl/control_actuadores.sv
// Fire-control sequencer: accumulates sensor pulses per scan frame, classifies each
// frame at EJECD and drives sprinkler/fan/alarm/mains-cut from the registered state.
//
// state    | meaning
// IDLE     | no hazard, all actuators off
// ALERTA   | warning: fan on, alarm unless silenced
// INCENDIO | fire: mains cut, alarm, sprinkler when mains absent
// ENFRIA   | cool-down: fan on, mains cut held if coming from fire
module control_actuadores #(
  parameter int unsigned HOLD_TICKS = 10
) (
  input logic                 Clk,
  input logic                 Reset,
  control_actuadores_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ALERTA   = 2'b01,
    INCENDIO = 2'b10,
    ENFRIA   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;   // {fTA, fTM, fH, fE}
  logic       pwr_on_q, pwr_on_d;
  logic       from_fire_q, from_fire_d;
  logic       silenced_q, silenced_d;

  logic ta, tm, h, e, fire, warn, entering, alarma;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      flags_q     <= 4'd0;
      pwr_on_q    <= 1'b0;
      from_fire_q <= 1'b0;
      silenced_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      pwr_on_q    <= pwr_on_d;
      from_fire_q <= from_fire_d;
      silenced_q  <= silenced_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    pwr_on_d    = pwr_on_q;
    from_fire_d = from_fire_q;
    silenced_d  = silenced_q;

    // Same-cycle pulses count toward the frame being closed.
    ta   = flags_q[3] | bus.TempAlto;
    tm   = flags_q[2] | bus.TempMedio;
    h    = flags_q[1] | bus.HumoOut;
    e    = flags_q[0] | bus.Elec;
    fire = ta | (h & tm);
    warn = (h | tm) & ~fire;

    if (bus.EJECD) begin
      flags_d  = 4'd0;
      pwr_on_d = e;
    end else begin
      flags_d = flags_q | {bus.TempAlto, bus.TempMedio, bus.HumoOut, bus.Elec};
    end

    case (state_q)
      IDLE: begin
        if (bus.EJECD && fire)      state_d = INCENDIO;
        else if (bus.EJECD && warn) state_d = ALERTA;
      end
      ALERTA: begin
        if (bus.EJECD && fire)       state_d = INCENDIO;
        else if (bus.EJECD && !warn) state_d = ENFRIA;
      end
      INCENDIO: begin
        if (bus.EJECD && !fire) state_d = ENFRIA;
      end
      ENFRIA: begin
        if (bus.EJECD && fire)      state_d = INCENDIO;
        else if (bus.EJECD && warn) state_d = ALERTA;
        else if (bus.Tick) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    entering = (state_d != state_q);
    alarma   = ((state_q == ALERTA) || (state_q == INCENDIO)) && !silenced_q;

    if (entering && state_d == ENFRIA) cnt_d = 8'(HOLD_TICKS);

    if (entering && state_d == INCENDIO)
      from_fire_d = 1'b1;
    else if (entering && (state_d == IDLE || state_d == ALERTA))
      from_fire_d = 1'b0;

    // A fresh alarm episode always sounds, even if Ack arrives on the same edge.
    if (entering && state_d != ENFRIA)
      silenced_d = 1'b0;
    else if (bus.Ack && alarma)
      silenced_d = 1'b1;
  end

  always_comb begin
    bus.Rociador   = 1'b0;
    bus.Ventilador = 1'b0;
    bus.Alarma     = 1'b0;
    bus.CorteElec  = 1'b0;
    bus.Estado     = state_q;
    case (state_q)
      ALERTA: begin
        bus.Ventilador = 1'b1;
        bus.Alarma     = ~silenced_q;
      end
      INCENDIO: begin
        bus.CorteElec = 1'b1;
        bus.Alarma    = ~silenced_q;
        bus.Rociador  = ~pwr_on_q;
      end
      ENFRIA: begin
        bus.Ventilador = 1'b1;
        bus.CorteElec  = from_fire_q;
      end
      default: ;
    endcase
  end

endmodule
